// File: rtl/seg7_pkg.sv
// Shared types, glyphs and the default message for the scrolling 7-segment driver.
package seg7_pkg;

  // Segment pattern {g,f,e,d,c,b,a}, logical 1 = segment lit
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h07;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;
  localparam seg_t GLYPH_H = 7'h76;
  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_E = 7'h79;
  localparam seg_t GLYPH_L = 7'h38;
  localparam seg_t GLYPH_P = 7'h73;

  localparam int unsigned DEFAULT_MSG_LEN = 8;

  // Entry 0 is the leftmost character at offset 0
  localparam seg_t DEFAULT_MSG [DEFAULT_MSG_LEN] = '{
    GLYPH_H, GLYPH_1, GLYPH_C, GLYPH_0, GLYPH_4, GLYPH_1, GLYPH_0, GLYPH_2
  };

  // Counter/address width that never collapses to zero bits
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Reset contents of message entry i; entries past the default text are blank
  function automatic seg_t default_entry(input int unsigned i);
    seg_t v;
    v = SEG_BLANK;
    for (int unsigned j = 0; j < DEFAULT_MSG_LEN; j++) begin
      if (j == i) v = DEFAULT_MSG[j];
    end
    return v;
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Enabled modulo-DIV counter producing a one-cycle pulse on its terminal count.
module clk_div_tick
  import seg7_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  // Masked during clear so a terminal count caught by reset never escapes
  assign o_tick = i_en && w_last && !i_clr;

  // Count 0..DIV-1 while enabled, hold value while disabled
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scroll_mux.sv
// Multiplexed, scrolling 7-segment driver with a writable message and key override.
module seg7_scroll_mux
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MSG_LEN        = 8,
  parameter int unsigned REFRESH_DIV    = 65536,
  parameter int unsigned SCROLL_DIV     = 67108864,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_msg_wr,
  input  logic [clog2_min1(MSG_LEN)-1:0] i_msg_addr,
  input  logic [6:0]                     i_msg_data,
  input  logic                           i_scroll_en,
  input  logic                           i_dir,
  input  logic                           i_print,
  input  logic [7:0]                     i_key,
  output logic [6:0]                     o_led,
  output logic [DIGITS-1:0]              o_ce,
  output logic                           o_step
);

  localparam int unsigned AW = clog2_min1(MSG_LEN);
  localparam int unsigned DW = clog2_min1(DIGITS);
  localparam seg_t LED_OFF = SEG_ACTIVE_LOW ? seg_t'(7'h7F) : SEG_BLANK;

  logic              w_ref_tick;
  logic              w_scr_tick;
  logic [DW-1:0]     r_digit;
  logic [AW-1:0]     r_offset;
  seg_t              r_msg [MSG_LEN];
  logic              w_addr_ok;
  logic [31:0]       w_sum;
  logic [AW-1:0]     w_idx;
  logic              w_key_onehot;
  logic [2:0]        w_key_idx;
  logic              w_key_ok;
  seg_t              w_pattern;
  logic [DIGITS-1:0] w_ce_next;
  logic [6:0]        r_led;
  logic [DIGITS-1:0] r_ce;
  logic              r_step;

  clk_div_tick #(
    .DIV (REFRESH_DIV)
  ) u_refresh (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_en   (1'b1),
    .o_tick (w_ref_tick)
  );

  clk_div_tick #(
    .DIV (SCROLL_DIV)
  ) u_scroll (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_en   (i_scroll_en),
    .o_tick (w_scr_tick)
  );

  // Digit index advances once per refresh slot, wrapping at DIGITS-1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digit <= '0;
    end else if (w_ref_tick) begin
      r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + DW'(1);
    end
  end

  // Scroll offset moves one entry per scroll step, modulo MSG_LEN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_offset <= '0;
    end else if (w_scr_tick) begin
      if (i_dir) begin
        r_offset <= (r_offset == '0) ? AW'(MSG_LEN - 1) : r_offset - AW'(1);
      end else begin
        r_offset <= (r_offset == AW'(MSG_LEN - 1)) ? '0 : r_offset + AW'(1);
      end
    end
  end

  // Zero-extend before comparing so the check holds for any MSG_LEN
  assign w_addr_ok = (32'(i_msg_addr) < MSG_LEN);

  // Message store: reloads the default text on reset, out-of-range writes dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        r_msg[i] <= default_entry(i);
      end
    end else if (i_msg_wr && w_addr_ok) begin
      r_msg[i_msg_addr] <= i_msg_data;
    end
  end

  // Sum never exceeds 2*max(MSG_LEN, DIGITS), so one modulo is exact
  assign w_sum = 32'(r_offset) + 32'(r_digit);
  assign w_idx = AW'(w_sum % MSG_LEN);

  // Select the pattern for the current digit: override entry or scrolled entry
  always_comb begin
    w_key_onehot = (i_key != 8'd0) && ((i_key & (i_key - 8'd1)) == 8'd0);
    w_key_idx    = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i_key[i]) w_key_idx = 3'(i);
    end
    w_key_ok  = w_key_onehot && (32'(w_key_idx) < MSG_LEN);
    w_pattern = SEG_BLANK;
    if (i_print) begin
      if (w_key_ok) w_pattern = r_msg[AW'(w_key_idx)];
    end else begin
      w_pattern = r_msg[w_idx];
    end
  end

  assign w_ce_next = ~(DIGITS'(1) << r_digit);

  // led and ce share one register stage so they always switch together
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led  <= LED_OFF;
      r_ce   <= '1;
      r_step <= 1'b0;
    end else begin
      r_led  <= SEG_ACTIVE_LOW ? ~w_pattern : w_pattern;
      r_ce   <= w_ce_next;
      r_step <= w_scr_tick;
    end
  end

  assign o_led  = r_led;
  assign o_ce   = r_ce;
  assign o_step = r_step;

endmodule

// File: tb/tb_seg7_scroll_mux.sv
// Scoreboard bench for seg7_scroll_mux: expected digit frames and step times are queued by
// the stimulus and popped by monitors whenever the DUT switches digit or pulses step.
module tb_seg7_scroll_mux;

  // Active-low drive values, hand-derived from the {g..a} glyph patterns
  localparam logic [6:0] L_H  = 7'h09;
  localparam logic [6:0] L_1  = 7'h79;
  localparam logic [6:0] L_C  = 7'h46;
  localparam logic [6:0] L_0  = 7'h40;
  localparam logic [6:0] L_4  = 7'h19;
  localparam logic [6:0] L_2  = 7'h24;
  localparam logic [6:0] L_E  = 7'h06;
  localparam logic [6:0] L_BL = 7'h7F;
  localparam logic [6:0] P_E  = 7'h79;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_wr = 1'b0;
  logic [2:0] msg_addr = 3'd0;
  logic [6:0] msg_data = 7'd0;
  logic       scroll_en = 1'b0;
  logic       dir = 1'b0;
  logic       print = 1'b0;
  logic [7:0] key = 8'd0;
  logic [6:0] led;
  logic [3:0] ce;
  logic       step;

  logic       wr2 = 1'b0;
  logic [2:0] addr2 = 3'd0;
  logic [6:0] data2 = 7'd0;
  logic [6:0] led2;
  logic [5:0] ce2;
  logic       step2;

  logic [10:0] q1[$];
  logic [12:0] q2[$];
  int          sq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  seg7_scroll_mux #(
    .DIGITS(4), .MSG_LEN(8), .REFRESH_DIV(4), .SCROLL_DIV(16), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_msg_wr(msg_wr), .i_msg_addr(msg_addr),
    .i_msg_data(msg_data), .i_scroll_en(scroll_en), .i_dir(dir), .i_print(print),
    .i_key(key), .o_led(led), .o_ce(ce), .o_step(step)
  );

  seg7_scroll_mux #(
    .DIGITS(6), .MSG_LEN(5), .REFRESH_DIV(4), .SCROLL_DIV(16), .SEG_ACTIVE_LOW(1'b1)
  ) u_odd (
    .i_clk(clk), .i_rst(rst), .i_msg_wr(wr2), .i_msg_addr(addr2),
    .i_msg_data(data2), .i_scroll_en(1'b0), .i_dir(1'b0), .i_print(1'b0),
    .i_key(8'd0), .o_led(led2), .o_ce(ce2), .o_step(step2)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

  // Monitor for the 4-digit instance: one comparison per digit switch
  initial begin
    logic [3:0]  prev;
    logic [10:0] exp;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (ce !== prev) begin
        prev = ce;
        if (q1.size() != 0) begin
          exp = q1.pop_front();
          total = total + 1;
          if ({ce, led} !== exp) begin
            bad = bad + 1;
            $display("FAIL disp4 t=%0d got ce=%b led=%h want ce=%b led=%h",
                     cyc, ce, led, exp[10:7], exp[6:0]);
          end
        end
      end
    end
  end

  // Monitor for the 6-digit / 5-entry instance
  initial begin
    logic [5:0]  prev;
    logic [12:0] exp;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (ce2 !== prev) begin
        prev = ce2;
        if (q2.size() != 0) begin
          exp = q2.pop_front();
          total = total + 1;
          if ({ce2, led2} !== exp) begin
            bad = bad + 1;
            $display("FAIL disp6 t=%0d got ce=%b led=%h want ce=%b led=%h",
                     cyc, ce2, led2, exp[12:7], exp[6:0]);
          end
        end
      end
    end
  end

  // Step monitor: every pulse must match the next queued cycle number
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      if (step === 1'b1) begin
        total = total + 1;
        if (sq.size() == 0) begin
          bad = bad + 1;
          $display("FAIL step_unexpected got=pulse@%0d want=none", cyc);
        end else begin
          exp = sq.pop_front();
          if (cyc != exp) begin
            bad = bad + 1;
            $display("FAIL step_time got=%0d want=%0d", cyc, exp);
          end
        end
      end
      if (step2 === 1'b1) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL step_odd got=pulse@%0d want=none", cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push1(input logic [3:0] c, input logic [6:0] l);
    q1.push_back({c, l});
  endtask

  // Frames for digits 1,2,3 then 0 when called during a digit-0 slot
  task automatic push_round(input logic [6:0] d1, input logic [6:0] d2,
                            input logic [6:0] d3, input logic [6:0] d0);
    push1(4'b1101, d1);
    push1(4'b1011, d2);
    push1(4'b0111, d3);
    push1(4'b1110, d0);
  endtask

  function automatic int qsize(input int which);
    if (which == 1) return q1.size();
    if (which == 2) return q2.size();
    return sq.size();
  endfunction

  task automatic drain(input int which);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qsize(which) != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain%0d got pending=%0d want=0", which, qsize(which));
    end
  endtask

  // Align to just after the edge where digit 0 becomes enabled
  task automatic sync_slot0;
    logic [3:0] last;
    bit found;
    last = ce;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(posedge clk);
      #1;
      if (ce == 4'b1110 && last != 4'b1110) found = 1'b1;
      last = ce;
    end
    if (!found) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL sync_slot0 got ce=%b want=1110", ce);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int c1;

    // Reset state
    tick(3);
    chk("rst_ce", 32'(ce), 32'hF);
    chk("rst_led", 32'(led), 32'(L_BL));
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_ce6", 32'(ce2), 32'h3F);
    chk("rst_led6", 32'(led2), 32'(L_BL));

    // Default message after release; odd instance repeats entry 0 on digit 5
    @(negedge clk);
    #1;
    push1(4'b1110, L_H);
    push_round(L_1, L_C, L_0, L_H);
    q2.push_back({6'b111110, L_H});
    q2.push_back({6'b111101, L_1});
    q2.push_back({6'b111011, L_C});
    q2.push_back({6'b110111, L_0});
    q2.push_back({6'b101111, L_4});
    q2.push_back({6'b011111, L_H});
    q2.push_back({6'b111110, L_H});
    rst = 1'b0;
    // Addresses past MSG_LEN=5 must not disturb the odd instance
    for (int a = 5; a < 8; a++) begin
      wr2 = 1'b1;
      addr2 = 3'(a);
      data2 = P_E;
      tick(1);
    end
    wr2 = 1'b0;
    drain(1);
    drain(2);

    // Scroll left 8 steps: full wrap back to offset 0
    tick(1);
    n0 = cyc;
    dir = 1'b0;
    scroll_en = 1'b1;
    for (int k = 1; k <= 8; k++) sq.push_back(n0 + 16 * k);
    tick(128);
    scroll_en = 1'b0;
    drain(3);
    sync_slot0();
    push_round(L_1, L_C, L_0, L_H);
    drain(1);

    // One step right from offset 0 lands on offset 7
    tick(1);
    n0 = cyc;
    dir = 1'b1;
    scroll_en = 1'b1;
    sq.push_back(n0 + 16);
    tick(16);
    scroll_en = 1'b0;
    drain(3);
    sync_slot0();
    push_round(L_H, L_1, L_C, L_2);
    drain(1);

    // Freeze at count 9 for 100 cycles, then 7 more cycles to the step (7 -> 0)
    tick(1);
    dir = 1'b0;
    scroll_en = 1'b1;
    tick(9);
    scroll_en = 1'b0;
    tick(100);
    n0 = cyc;
    scroll_en = 1'b1;
    sq.push_back(n0 + 7);
    tick(7);
    scroll_en = 1'b0;
    drain(3);

    // Key override: entry 2 everywhere, then non-one-hot key blanks, then release
    sync_slot0();
    print = 1'b1;
    key = 8'b0000_0100;
    push_round(L_C, L_C, L_C, L_C);
    drain(1);
    key = 8'b0000_0110;
    push_round(L_BL, L_BL, L_BL, L_BL);
    drain(1);
    print = 1'b0;
    push_round(L_1, L_C, L_0, L_H);
    drain(1);

    // Write entry 3 in the same cycle digit 3 is read: old value now, new next visit
    push_round(L_1, L_C, L_0, L_H);
    push_round(L_1, L_C, L_E, L_H);
    tick(11);
    msg_wr = 1'b1;
    msg_addr = 3'd3;
    msg_data = P_E;
    tick(1);
    msg_wr = 1'b0;
    drain(1);

    // Reset while scrolling with offset 2 and scroll count 8
    tick(1);
    n0 = cyc;
    scroll_en = 1'b1;
    sq.push_back(n0 + 16);
    sq.push_back(n0 + 32);
    tick(40);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_ce", 32'(ce), 32'hF);
    chk("mid_rst_led", 32'(led), 32'(L_BL));
    chk("mid_rst_step", 32'(step), 32'h0);
    c1 = cyc;
    @(negedge clk);
    #1;
    push1(4'b1110, L_H);
    push1(4'b1101, L_1);
    push1(4'b1011, L_C);
    push1(4'b0111, L_0);
    sq.push_back(c1 + 16);
    rst = 1'b0;
    drain(1);
    drain(3);
    scroll_en = 1'b0;
    tick(4);

    chk("q4_empty", 32'(q1.size()), 32'h0);
    chk("q6_empty", 32'(q2.size()), 32'h0);
    chk("step_q_empty", 32'(sq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
